// File: rtl/mx_block_quantizer_int_pkg.sv
`default_nettype none
// ============================================================================
// mx_pkg: shared constants, types and helpers for the MX-int block quantizer
// Revision: 1.0
// ============================================================================
package mx_pkg;

  localparam int DEF_SCALE_WIDTH = 8;
  localparam int DEF_SCALE_BIAS  = 127;

  typedef logic [DEF_SCALE_WIDTH-1:0] scale_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_QUANT = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  // Width of an index able to address n items; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mx_block_quantizer_int_if.sv
`default_nettype none
// ============================================================================
// mx_block_quantizer_int_if: element stream in, quantized block + scale out
// Revision: 1.0
// ============================================================================
interface mx_block_quantizer_int_if #(
  parameter int K           = 32,
  parameter int IN_WIDTH    = 24,
  parameter int BIT_WIDTH   = 8,
  parameter int SCALE_WIDTH = 8
);

  logic                              i_valid;
  logic                              o_ready;
  logic signed [IN_WIDTH-1:0]        i_data;
  logic                              i_last;
  logic                              o_valid;
  logic                              i_ready;
  logic [K-1:0][BIT_WIDTH-1:0]       o_block;
  logic [SCALE_WIDTH-1:0]            o_scale;

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_block, o_scale
  );

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_block, o_scale
  );

endinterface
`default_nettype wire

// File: rtl/mx_block_quantizer_int_msb_detect.sv
`default_nettype none
// ============================================================================
// msb_detect: leading-one index of an unsigned value, plus an all-zero flag
// Revision: 1.0
// ============================================================================
module msb_detect
  import mx_pkg::*;
#(
  parameter int W  = 24,
  parameter int IW = cnt_width(W)
) (
  input  logic [W-1:0]  val_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o
);

  // Ascending scan so the highest set bit is the last to write the index.
  always_comb begin
    idx_o  = '0;
    zero_o = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (val_i[i]) begin
        idx_o  = IW'(i);
        zero_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mx_block_quantizer_int.sv
`default_nettype none
// ============================================================================
// mx_block_quantizer_int: streams signed fixed-point elements into MX-int
// blocks of K elements sharing one biased power-of-two scale.
// Revision: 1.0
// ============================================================================
module mx_block_quantizer_int
  import mx_pkg::*;
#(
  parameter int K           = 32,
  parameter int IN_WIDTH    = 24,
  parameter int BIT_WIDTH   = 8,
  parameter int SCALE_WIDTH = DEF_SCALE_WIDTH,
  parameter int SCALE_BIAS  = DEF_SCALE_BIAS
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  mx_block_quantizer_int_if.slave  bus
);

  localparam int CW   = cnt_width(K);
  localparam int MW   = $clog2(IN_WIDTH + 2);
  localparam int IDXW = cnt_width(IN_WIDTH);
  localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH+1)'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH:0] SAT_LO = -SAT_HI;

  state_t                      state_q;
  logic [CW-1:0]               count_q;
  logic [IN_WIDTH-1:0]         buf_q [K];
  logic [MW-1:0]               maxp1_q;
  logic                        ready_q;
  logic                        valid_q;
  logic [K-1:0][BIT_WIDTH-1:0] block_q;
  logic [SCALE_WIDTH-1:0]      scale_q;

  logic                        accept;
  logic                        blk_done;
  logic [IN_WIDTH-1:0]         mag;
  logic [IDXW-1:0]             msb_idx;
  logic                        msb_zero;
  logic [MW-1:0]               msbp1;
  logic [MW-1:0]               maxp1_d;
  logic [MW-1:0]               shift;
  logic [K-1:0][BIT_WIDTH-1:0] lane_d;

  assign accept   = (state_q == ST_FILL) && ready_q && bus.i_valid;
  assign blk_done = bus.i_last || (count_q == CW'(K - 1));

  // Two's-complement magnitude; the most-negative input maps to 2^(IN_WIDTH-1).
  assign mag = bus.i_data[IN_WIDTH-1] ? (~bus.i_data + IN_WIDTH'(1)) : bus.i_data;

  msb_detect #(
    .W  (IN_WIDTH),
    .IW (IDXW)
  ) u_msb_detect (
    .val_i  (mag),
    .idx_o  (msb_idx),
    .zero_o (msb_zero)
  );

  // Track msb+1 so an empty or all-zero block sits naturally at 0.
  assign msbp1   = msb_zero ? '0 : (MW'(msb_idx) + MW'(1));
  assign maxp1_d = (msbp1 > maxp1_q) ? msbp1 : maxp1_q;
  assign shift   = (maxp1_q > MW'(BIT_WIDTH - 1)) ? (maxp1_q - MW'(BIT_WIDTH - 1)) : '0;

  function automatic logic [BIT_WIDTH-1:0] quant_lane(
    input logic [IN_WIDTH-1:0] x,
    input logic [MW-1:0]       s
  );
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] y;
    logic [BIT_WIDTH-1:0]     r;
    ext = $signed({x[IN_WIDTH-1], x});
    rnd = '0;
    if (s != '0) begin
      rnd = (IN_WIDTH+1)'(1) << (s - MW'(1));
    end
    y = (ext + rnd) >>> s;
    if (y > SAT_HI) begin
      r = SAT_HI[BIT_WIDTH-1:0];
    end else if (y < SAT_LO) begin
      r = SAT_LO[BIT_WIDTH-1:0];
    end else begin
      r = y[BIT_WIDTH-1:0];
    end
    return r;
  endfunction

  for (genvar g = 0; g < K; g++) begin : g_lane
    assign lane_d[g] = quant_lane(buf_q[g], shift);
  end

  // Unfilled slots stay zero because the buffer is cleared whenever a block retires.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_FILL;
      count_q <= '0;
      maxp1_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      block_q <= '0;
      scale_q <= '0;
      for (int i = 0; i < K; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        ST_FILL: begin
          if (accept) begin
            buf_q[count_q] <= bus.i_data;
            count_q        <= count_q + CW'(1);
            maxp1_q        <= maxp1_d;
            if (blk_done) begin
              state_q <= ST_QUANT;
              ready_q <= 1'b0;
            end
          end
        end
        ST_QUANT: begin
          block_q <= lane_d;
          scale_q <= SCALE_WIDTH'(SCALE_BIAS + int'(shift));
          valid_q <= 1'b1;
          state_q <= ST_EMIT;
        end
        ST_EMIT: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            count_q <= '0;
            maxp1_q <= '0;
            state_q <= ST_FILL;
            for (int i = 0; i < K; i++) begin
              buf_q[i] <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_block = block_q;
  assign bus.o_scale = scale_q;

endmodule
`default_nettype wire

// File: tb/tb_mx_block_quantizer_int.sv
`default_nettype none
// ============================================================================
// tb_mx_block_quantizer_int: directed vectors for the MX-int block quantizer
// Revision: 1.0
// ============================================================================
module tb_mx_block_quantizer_int;

  localparam int K   = 4;
  localparam int IW  = 16;
  localparam int BW  = 8;
  localparam int SCW = 8;
  localparam int SB  = 127;

  logic i_clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  mx_block_quantizer_int_if #(.K(K), .IN_WIDTH(IW), .BIT_WIDTH(BW), .SCALE_WIDTH(SCW)) bus ();

  mx_block_quantizer_int #(
    .K(K), .IN_WIDTH(IW), .BIT_WIDTH(BW), .SCALE_WIDTH(SCW), .SCALE_BIAS(SB)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0][15:0] d;
    int               n;
    bit               last;
    bit               pre_rdy;
    logic [3:0][7:0]  eb;
    logic [7:0]       es;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [3:0][15:0] mk16(input int a, input int b, input int c, input int e);
    logic [3:0][15:0] r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(e);
    return r;
  endfunction

  function automatic logic [3:0][7:0] mk8(input int a, input int b, input int c, input int e);
    logic [3:0][7:0] r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(e);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the final element's accepting edge.
  task automatic send_elems(input logic [3:0][15:0] d, input int n, input bit last_on_final);
    int guard;
    for (int i = 0; i < n; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = d[i];
      bus.i_last  = last_on_final && (i == n - 1);
      guard = 0;
      while (!bus.o_ready && guard < 100) begin
        @(negedge i_clk);
        guard++;
      end
      if (guard >= 100) chk("ready_timeout", 64'(bus.o_ready), 64'd1);
      @(negedge i_clk);
    end
    bus.i_valid = 1'b0;
    bus.i_last  = 1'b0;
    bus.i_data  = '0;
  endtask

  task automatic expect_block(input logic [3:0][7:0] eb, input logic [7:0] es);
    chk("valid_t1", 64'(bus.o_valid), 64'd0);
    chk("ready_busy", 64'(bus.o_ready), 64'd0);
    @(negedge i_clk);
    chk("valid_t2", 64'(bus.o_valid), 64'd1);
    chk("block", 64'(bus.o_block), 64'(eb));
    chk("scale", 64'(bus.o_scale), 64'(es));
  endtask

  task automatic handshake();
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    bus.i_ready = 1'b0;
    chk("hs_valid", 64'(bus.o_valid), 64'd0);
    chk("hs_ready", 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mk16(100, -50, 3, 0),       4, 1'b0, 1'b0, mk8(100, -50, 3, 0),   8'd127};
    vecs[1] = '{mk16(1000, -1000, 4, 5),    4, 1'b0, 1'b0, mk8(125, -125, 1, 1),  8'd130};
    vecs[2] = '{mk16(1020, 0, 0, 0),        4, 1'b0, 1'b0, mk8(127, 0, 0, 0),     8'd130};
    vecs[3] = '{mk16(-32768, 0, 0, 0),      4, 1'b0, 1'b0, mk8(-64, 0, 0, 0),     8'd136};
    vecs[4] = '{mk16(7, 0, 0, 0),           1, 1'b1, 1'b0, mk8(7, 0, 0, 0),       8'd127};
    vecs[5] = '{mk16(0, 0, 0, 0),           4, 1'b0, 1'b0, mk8(0, 0, 0, 0),       8'd127};
    vecs[6] = '{mk16(10, 20, -30, 40),      4, 1'b1, 1'b0, mk8(10, 20, -30, 40),  8'd127};
    vecs[7] = '{mk16(-1, -128, 127, 64),    4, 1'b0, 1'b1, mk8(0, -64, 64, 32),   8'd128};
    vecs[8] = '{mk16(300, -3, 0, 0),        2, 1'b1, 1'b0, mk8(75, -1, 0, 0),     8'd129};
    vecs[9] = '{mk16(-6, -5, -127, -128),   4, 1'b0, 1'b0, mk8(-3, -2, -63, -64), 8'd128};

    i_rst       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_block", 64'(bus.o_block), 64'd0);
    chk("rst_scale", 64'(bus.o_scale), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", 64'(bus.o_ready), 64'd1);

    for (int v = 0; v < 10; v++) begin
      bus.i_ready = vecs[v].pre_rdy;
      send_elems(vecs[v].d, vecs[v].n, vecs[v].last);
      expect_block(vecs[v].eb, vecs[v].es);
      handshake();
    end

    // Backpressure: block must hold and input must be refused while stalled.
    send_elems(mk16(1000, -1000, 4, 5), 4, 1'b0);
    expect_block(mk8(125, -125, 1, 1), 8'd130);
    for (int c = 0; c < 10; c++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 16'sh1234;
      @(negedge i_clk);
      chk("bp_valid", 64'(bus.o_valid), 64'd1);
      chk("bp_ready", 64'(bus.o_ready), 64'd0);
      chk("bp_block", 64'(bus.o_block), 64'(mk8(125, -125, 1, 1)));
      chk("bp_scale", 64'(bus.o_scale), 64'd130);
    end
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    handshake();
    send_elems(mk16(100, -50, 3, 0), 4, 1'b0);
    expect_block(mk8(100, -50, 3, 0), 8'd127);
    handshake();

    // Reset mid-fill: partial large elements must not leak into the next block.
    send_elems(mk16(30000, -30000, 0, 0), 2, 1'b0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rstf_valid", 64'(bus.o_valid), 64'd0);
    chk("rstf_ready", 64'(bus.o_ready), 64'd1);
    send_elems(mk16(7, 0, 0, 0), 1, 1'b1);
    expect_block(mk8(7, 0, 0, 0), 8'd127);
    handshake();

    // Reset during emit: pending block is dropped.
    send_elems(mk16(30000, -30000, 5, 5), 4, 1'b0);
    expect_block(mk8(117, -117, 0, 0), 8'd135);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rste_valid", 64'(bus.o_valid), 64'd0);
    chk("rste_ready", 64'(bus.o_ready), 64'd1);
    send_elems(mk16(100, -50, 3, 0), 4, 1'b0);
    expect_block(mk8(100, -50, 3, 0), 8'd127);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
